// File: rtl/spi_tx_pkg.sv
// rtl/spi_tx_pkg.sv - shared types and constants for the SPI transmit arbiter
package spi_tx_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEF_LEN_W       = 4;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_rr_pick.sv
// rtl/spi_tx_arbiter_rr_pick.sv - combinational round-robin picker: first set
// request at or after ptr_i, with wrap; reusable by other arbiters.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan farthest-to-nearest so the request closest to ptr_i is written last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req_i[(int'(ptr_i) + off) % N]) begin
        grant_o                           = '0;
        grant_o[(int'(ptr_i) + off) % N]  = 1'b1;
        idx_o                             = IDX_W'((int'(ptr_i) + off) % N);
        any_o                             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - round-robin arbiter feeding one SPI serializer byte by byte.
// Optional sent timeout enabled by macro SPI_TX_TIMEOUT_EN.
module spi_tx_arbiter
  import spi_tx_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        byte_ack,
  output logic [NUM_REQ-1:0]        frame_done,
  output logic                      err,
  output logic                      busy,
  output logic                      spi_en,
  output logic [BYTE_W-1:0]         spi_data,
  input  logic                      spi_sent
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("spi_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                sent_q;
  logic                sent_edge;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

`ifdef SPI_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0]       wcnt_q, wcnt_d;
  logic                err_q, err_d;
`endif

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // A sent level that was already high when we started waiting is not an edge.
  assign sent_edge = spi_sent & ~sent_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    en_d     = 1'b0;
    ack_d    = '0;
    done_d   = '0;
`ifdef SPI_TX_TIMEOUT_EN
    wcnt_d   = wcnt_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d  = pick_oh;
          gidx_d   = pick_idx;
          cnt_d    = req_len[int'(pick_idx)*LEN_W +: LEN_W];
          rr_ptr_d = IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_d  = req_data[int'(gidx_q)*BYTE_W +: BYTE_W];
        en_d    = 1'b1;
        ack_d   = grant_q;
        state_d = ST_WAIT;
`ifdef SPI_TX_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      ST_WAIT: begin
        if (sent_edge) begin
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = ST_LOAD;
          end
        end
`ifdef SPI_TX_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          wcnt_d  = wcnt_q + TW'(1);
        end
`endif
      end
      ST_DONE: begin
        done_d  = grant_q;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      en_q     <= en_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      sent_q   <= spi_sent;
    end
  end

`ifdef SPI_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign grant      = grant_q;
  assign byte_ack   = ack_q;
  assign frame_done = done_q;
  assign busy       = busy_q;
  assign spi_en     = en_q;
  assign spi_data   = data_q;

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares one outputSPI serializer between NUM_REQ requesters, e.g. cipher engine and status/debug reporter.
- Picks a requester round-robin and latches its frame length.
- Feeds the frame to outputSPI one byte at a time: en pulse plus 8-bit in; waits for sent before the next byte.
- Sits between the crypto datapath and the outputSPI instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- LEN_W, 4, width of per-requester length field; frame = len+1 bytes (1..2^LEN_W).
- TIMEOUT_CYC, 1024, cycles to wait for sent before abort (used only with SPI_TX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level; requester i has a frame pending.
- req_len  in  NUM_REQ*LEN_W  per-requester byte count minus 1; sampled at grant.
- req_data  in  NUM_REQ*8  per-requester current byte; must be valid while granted.
- grant  out  NUM_REQ  one-hot owner of the serializer; 0 when idle.
- byte_ack  out  NUM_REQ  1-cycle pulse: byte taken, requester advances req_data.
- frame_done  out  NUM_REQ  1-cycle pulse after last byte's sent.
- err  out  1  1-cycle pulse on timeout abort; constant 0 without macro.
- busy  out  1  high in any state except IDLE.
- spi_en  out  1  to outputSPI en; 1-cycle pulse per byte.
- spi_data  out  8  to outputSPI in; held stable from pulse until next load.
- spi_sent  in  1  from outputSPI sent.

Behaviour:
- Reset (rst=0, async): state=IDLE. grant, byte_ack, frame_done, err, busy, spi_en = 0. spi_data=8'h00. rr_ptr=0. byte counter=0. sent_q=0.
- Reset mid-frame: all of the above immediately; the partial frame is dropped with no frame_done.
- States: IDLE -> LOAD -> WAIT -> (LOAD | DONE) -> IDLE. All outputs are registered.
- IDLE:
  - If any req bit is set: choose the first set bit searching from rr_ptr upward with wrap.
  - Set grant one-hot, cnt <= req_len[g], rr_ptr <= g+1 (mod NUM_REQ), go to LOAD.
- LOAD (one cycle):
  - spi_data <= req_data[g], spi_en <= 1, byte_ack[g] <= 1, go to WAIT.
  - spi_en and byte_ack are therefore high exactly one cycle, 2 cycles after req is sampled in IDLE.
- WAIT:
  - spi_en=0. Wait for a rising edge of spi_sent, detected with sent_q; a stale-high sent is ignored.
  - On edge: if cnt==0 go to DONE, else cnt <= cnt-1 and go to LOAD.
- DONE (one cycle): frame_done[g] pulse, grant <= 0, go to IDLE. A new grant is possible on the following cycle.
- req deassert while granted: ignored; the frame always completes its latched length.
- req_len change mid-frame: ignored.
- Simultaneous requests: strict round-robin. With requesters 0 and 1 always requesting, frames alternate 0,1,0,1.
- A sent edge outside WAIT is discarded.

Optional Feature:
- Macro SPI_TX_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYC-1 without a sent edge: err pulse, grant <= 0, no frame_done, go to IDLE. rr_ptr keeps its advanced value.
- Undefined: no counter; WAIT lasts indefinitely; err tied 0.

Decomposition:
- Package spi_tx_pkg: state encoding constants (IDLE, LOAD, WAIT, DONE), byte width 8, default LEN_W/TIMEOUT_CYC.
- One sub-module rr_pick: combinational, req vector plus rr_ptr -> one-hot grant and index plus any_req. Kept separate so it can be reused by the input-side arbiter.

Test Plan:
- Single frame: req[0]=1, len=2, data 8'hA1,A2,A3; pulse spi_sent 20 cycles after each spi_en.
  - Expect 3 spi_en pulses with spi_data A1,A2,A3, 3 byte_ack[0] pulses, then frame_done[0]; grant back to 0.
- Contention: req=2'b11 held, len=0 each.
  - Expect grants 01,10,01,10 across 4 frames; first grant to requester 0 after reset.
- Stale sent: spi_sent held high before the grant.
  - Expect no early advance; the second byte loads only after sent goes 0 then 1.
- Reset mid-frame: rst=0 during WAIT of byte 2 of 4.
  - Expect all outputs 0 immediately, no frame_done, rr_ptr=0.
  - After release, the next req is served from byte 1.
- Max length: len=4'hF.
  - Expect exactly 16 bytes and one frame_done; no wrap of cnt.
- Timeout (with SPI_TX_TIMEOUT_EN, TIMEOUT_CYC=8): never pulse spi_sent.
  - Expect err pulse 8 cycles into WAIT, grant 0, no frame_done, IDLE.
